// File: rtl/riscy_mem_arbiter.sv
// Two-to-one req/gnt/rvalid arbiter sharing one memory port between RI5CY fetch and data.
// Define RISCY_ARB_RR_EN for round-robin on ties; otherwise data has fixed priority over fetch.
module riscy_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        spurious_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Handshake: a request is accepted in the cycle where mem_req_o && mem_gnt_i; each
    // accepted request is answered by exactly one later mem_rvalid_i, in issue order.

    state_e                     state_q, state_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;

    logic        hold_owner_q, hold_owner_d;
    logic        hold_we_q, hold_we_d;
    logic [3:0]  hold_be_q, hold_be_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;

`ifdef RISCY_ARB_RR_EN
    logic last_winner_q, last_winner_d;
`endif

    logic        full;
    logic        empty;
    logic        win_data;
    logic        sel_req;
    logic        sel_owner;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        grant;
    logic        pop;
    logic        head_owner;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full  = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty = (count_q == '0);
`ifdef RISCY_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        win_data = data_req_i & (~instr_req_i | (last_winner_q == OWNER_INSTR));
`else
        win_data = data_req_i;
`endif
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_owner = OWNER_INSTR;
        sel_we    = 1'b0;
        sel_be    = 4'h0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        if (state_q == HOLD) begin
            sel_req   = 1'b1;
            sel_owner = hold_owner_q;
            sel_we    = hold_we_q;
            sel_be    = hold_be_q;
            sel_addr  = hold_addr_q;
            sel_wdata = hold_wdata_q;
        end else if ((instr_req_i | data_req_i) & ~full) begin
            sel_req = 1'b1;
            if (win_data) begin
                sel_owner = OWNER_DATA;
                sel_we    = data_we_i;
                sel_be    = data_be_i;
                sel_addr  = data_addr_i;
                sel_wdata = data_wdata_i;
            end else begin
                sel_owner = OWNER_INSTR;
                sel_we    = 1'b0;
                sel_be    = 4'hF;
                sel_addr  = instr_addr_i;
                sel_wdata = 32'h0;
            end
        end
    end

    // Every output is forced low while reset is held, even with live requests.
    always_comb begin
        mem_req_o   = sel_req & rst_ni;
        mem_we_o    = sel_we & rst_ni;
        mem_be_o    = sel_be & {4{rst_ni}};
        mem_addr_o  = sel_addr & {32{rst_ni}};
        mem_wdata_o = sel_wdata & {32{rst_ni}};

        grant       = mem_req_o & mem_gnt_i;
        instr_gnt_o = grant & (sel_owner == OWNER_INSTR);
        data_gnt_o  = grant & (sel_owner == OWNER_DATA);

        head_owner     = fifo_q[rd_ptr_q];
        pop            = rst_ni & mem_rvalid_i & ~empty;
        spurious_o     = rst_ni & mem_rvalid_i & empty;
        instr_rvalid_o = pop & (head_owner == OWNER_INSTR);
        data_rvalid_o  = pop & (head_owner == OWNER_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
    end

    always_comb begin
        state_d      = state_q;
        hold_owner_d = hold_owner_q;
        hold_we_d    = hold_we_q;
        hold_be_d    = hold_be_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        unique case (state_q)
            ARB: begin
                if (sel_req && !mem_gnt_i) begin
                    state_d      = HOLD;
                    hold_owner_d = sel_owner;
                    hold_we_d    = sel_we;
                    hold_be_d    = sel_be;
                    hold_addr_d  = sel_addr;
                    hold_wdata_d = sel_wdata;
                end
            end
            HOLD: begin
                if (mem_gnt_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (grant) begin
            fifo_d[wr_ptr_q] = sel_owner;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`ifdef RISCY_ARB_RR_EN
        last_winner_d = grant ? sel_owner : last_winner_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ARB;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fifo_q        <= '0;
            hold_owner_q  <= OWNER_INSTR;
            hold_we_q     <= 1'b0;
            hold_be_q     <= 4'h0;
            hold_addr_q   <= 32'h0;
            hold_wdata_q  <= 32'h0;
`ifdef RISCY_ARB_RR_EN
            last_winner_q <= OWNER_DATA;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_q        <= fifo_d;
            hold_owner_q  <= hold_owner_d;
            hold_we_q     <= hold_we_d;
            hold_be_q     <= hold_be_d;
            hold_addr_q   <= hold_addr_d;
            hold_wdata_q  <= hold_wdata_d;
`ifdef RISCY_ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// Bench for riscy_mem_arbiter: vector table for arbitration/full behaviour plus hand sequences
// for single fetch, store hold, push/pop at count 1, spurious response and mid-flight reset.
module tb_riscy_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        spurious_o;

    always #5 clk = ~clk;

    riscy_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .spurious_o     (spurious_o)
    );

    // Scoreboard entry: {owner (1 = data), response data}.
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        exp_irv, exp_drv, exp_spur;
    logic [31:0] exp_rdata;

    typedef struct {
        logic ir;
        logic dr;
        logic mg;
        logic rv;
        logic ereq;
        logic eig;
        logic edg;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic ir, input logic dr, input logic mg, input logic rv,
                                input logic ereq, input logic ig_fp, input logic dg_fp,
                                input logic ig_rr, input logic dg_rr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.mg = mg; v.rv = rv; v.ereq = ereq;
`ifdef RISCY_ARB_RR_EN
        v.eig = ig_rr; v.edg = dg_rr;
`else
        v.eig = ig_fp; v.edg = dg_fp;
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle's inputs at the falling edge; pops the scoreboard for a response.
    task automatic cycle_in(input logic ir, input logic [31:0] ia, input logic dr,
                            input logic dwe, input logic [3:0] dbe, input logic [31:0] da,
                            input logic [31:0] dwd, input logic mg, input logic rv);
        logic [32:0] e;
        @(negedge clk);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = da;
        data_wdata_i = dwd;
        mem_gnt_i    = mg;
        mem_rvalid_i = rv;
        mem_rdata_i  = $urandom;
        exp_irv = 1'b0; exp_drv = 1'b0; exp_spur = 1'b0; exp_rdata = 32'h0;
        if (rv) begin
            if (exp_q.size() == 0) begin
                exp_spur = 1'b1;
            end else begin
                e = exp_q.pop_front();
                mem_rdata_i = e[31:0];
                exp_rdata   = e[31:0];
                exp_irv     = ~e[32];
                exp_drv     = e[32];
            end
        end
        #2;
    endtask

    task automatic check_resp();
        chk("instr_rvalid", {31'h0, instr_rvalid_o}, {31'h0, exp_irv});
        chk("data_rvalid", {31'h0, data_rvalid_o}, {31'h0, exp_drv});
        chk("instr_rdata", instr_rdata_o, exp_irv ? exp_rdata : 32'h0);
        chk("data_rdata", data_rdata_o, exp_drv ? exp_rdata : 32'h0);
        chk("spurious", {31'h0, spurious_o}, {31'h0, exp_spur});
    endtask

    task automatic check_gnt(input logic eig, input logic edg, input logic [31:0] rd);
        chk("instr_gnt", {31'h0, instr_gnt_o}, {31'h0, eig});
        chk("data_gnt", {31'h0, data_gnt_o}, {31'h0, edg});
        if (eig) exp_q.push_back({1'b0, rd});
        if (edg) exp_q.push_back({1'b1, rd});
    endtask

    task automatic check_mem(input logic req, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wd);
        chk("mem_req", {31'h0, mem_req_o}, {31'h0, req});
        if (req) begin
            chk("mem_we", {31'h0, mem_we_o}, {31'h0, we});
            chk("mem_be", {28'h0, mem_be_o}, {28'h0, be});
            chk("mem_addr", mem_addr_o, addr);
            chk("mem_wdata", mem_wdata_o, wd);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_instr_gnt"}, {31'h0, instr_gnt_o}, 32'h0);
        chk({tag, "_data_gnt"}, {31'h0, data_gnt_o}, 32'h0);
        chk({tag, "_instr_rvalid"}, {31'h0, instr_rvalid_o}, 32'h0);
        chk({tag, "_data_rvalid"}, {31'h0, data_rvalid_o}, 32'h0);
        chk({tag, "_instr_rdata"}, instr_rdata_o, 32'h0);
        chk({tag, "_data_rdata"}, data_rdata_o, 32'h0);
        chk({tag, "_mem_req"}, {31'h0, mem_req_o}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we_o}, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, mem_be_o}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk({tag, "_spurious"}, {31'h0, spurious_o}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [31:0] ia, da, dwd;
        logic        dwe;
        logic [3:0]  dbe;

        //               ir dr mg rv req  fp:ig dg  rr:ig dg
        vecs[0]  = mk(1, 1, 1, 0, 1,   0, 1,   1, 0);
        vecs[1]  = mk(1, 1, 1, 1, 1,   0, 1,   0, 1);
        vecs[2]  = mk(1, 1, 1, 1, 1,   0, 1,   1, 0);
        vecs[3]  = mk(1, 1, 1, 1, 1,   0, 1,   0, 1);
        vecs[4]  = mk(0, 0, 0, 1, 0,   0, 0,   0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 0,   0, 0,   0, 0);
        vecs[6]  = mk(1, 0, 1, 0, 1,   1, 0,   1, 0);
        vecs[7]  = mk(0, 1, 1, 0, 1,   0, 1,   0, 1);
        vecs[8]  = mk(1, 1, 1, 0, 0,   0, 0,   0, 0);
        vecs[9]  = mk(1, 1, 1, 1, 0,   0, 0,   0, 0);
        vecs[10] = mk(1, 1, 1, 1, 1,   0, 1,   1, 0);
        vecs[11] = mk(0, 0, 0, 1, 0,   0, 0,   0, 0);

        // Reset state, with live requests held during reset.
        #3;
        instr_req_i = 1'b1; instr_addr_i = 32'h40; data_req_i = 1'b1; data_addr_i = 32'h80;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #2;
        check_all_zero("reset");
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        do_reset();

        // Table: simultaneous requests, spurious, full stall, release after first response.
        for (int i = 0; i < 12; i++) begin
            ia  = $urandom & 32'hFFFF_FFFC;
            da  = $urandom & 32'hFFFF_FFFC;
            dwd = $urandom;
            dwe = 1'($urandom_range(0, 1));
            dbe = 4'($urandom_range(0, 15));
            cycle_in(vecs[i].ir, ia, vecs[i].dr, dwe, dbe, da, dwd, vecs[i].mg, vecs[i].rv);
            if (vecs[i].eig)
                check_mem(1'b1, 1'b0, 4'hF, ia, 32'h0);
            else if (vecs[i].edg)
                check_mem(1'b1, dwe, dbe, da, dwd);
            else
                check_mem(vecs[i].ereq, 1'b0, 4'h0, 32'h0, 32'h0);
            check_resp();
            check_gnt(vecs[i].eig, vecs[i].edg, $urandom);
        end
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Single fetch with combinational grant, response next cycle.
        cycle_in(1, 32'h80, 0, 0, 0, 0, 0, 1, 0);
        check_mem(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        check_gnt(1'b1, 1'b0, 32'h1B);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_resp();
        check_gnt(1'b0, 1'b0, 32'h0);

        // Store held off for 3 cycles; a fetch raised in cycle 2 must wait.
        for (int c = 1; c <= 3; c++) begin
            cycle_in(c >= 2, 32'h200, 1, 1, 4'h3, 32'h100, 32'hDEAD_BEEF, 0, 0);
            check_mem(1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF);
            check_gnt(1'b0, 1'b0, 32'h0);
        end
        cycle_in(1, 32'h200, 1, 1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1, 0);
        check_mem(1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF);
        check_gnt(1'b0, 1'b1, 32'hCAFE_0001);
        cycle_in(1, 32'h200, 0, 0, 0, 0, 0, 1, 1);
        check_mem(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        check_resp();
        check_gnt(1'b1, 1'b0, 32'hCAFE_0002);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_resp();

        // Push and pop together at count 1 keeps count at 1: one more grant then fills.
        cycle_in(1, 32'h300, 0, 0, 0, 0, 0, 1, 0);
        check_gnt(1'b1, 1'b0, 32'h1111_0000);
        cycle_in(0, 0, 1, 0, 4'hF, 32'h400, 32'h0, 1, 1);
        check_resp();
        check_gnt(1'b0, 1'b1, 32'h2222_0000);
        cycle_in(1, 32'h304, 0, 0, 0, 0, 0, 1, 0);
        check_mem(1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
        check_gnt(1'b1, 1'b0, 32'h3333_0000);
        cycle_in(1, 32'h308, 1, 0, 4'hF, 32'h404, 32'h0, 1, 0);
        check_mem(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_gnt(1'b0, 1'b0, 32'h0);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_resp();
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_resp();

        // Mid-flight reset with two outstanding, then a late response is spurious.
        cycle_in(1, 32'h500, 0, 0, 0, 0, 0, 1, 0);
        check_gnt(1'b1, 1'b0, 32'h5555_0000);
        cycle_in(0, 0, 1, 1, 4'hF, 32'h600, 32'h77, 1, 0);
        check_gnt(1'b0, 1'b1, 32'h6666_0000);
        @(negedge clk);
        rst_ni = 1'b0;
        exp_q.delete();
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        #2;
        check_all_zero("midreset");
        @(negedge clk);
        rst_ni = 1'b1;
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_resp();
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_resp();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscy_mem_arbiter.md
# riscy_mem_arbiter

Two-to-one memory arbiter that lets the RI5CY core's instruction-fetch port and data port share a single-port memory using the same req/gnt/rvalid protocol the core speaks. It sits between the core and the memory model or bus slave in the `testing_riscy` environment. It tracks outstanding transactions in an in-order owner FIFO so each response is routed back to the requester that issued it.

## Interface
- MAX_OUTSTANDING, default 2: owner-FIFO depth; maximum granted-but-unanswered transactions (1..8).
- clk  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- data_req_i  in  1  load/store request
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  32  load/store address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store accepted this cycle
- data_rvalid_o  out  1  load/store response valid
- data_rdata_o  out  32  load data
- mem_req_o / mem_we_o / mem_be_o[3:0] / mem_addr_o[31:0] / mem_wdata_o[31:0]  out  memory request channel
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data
- spurious_o  out  1  one-cycle pulse: mem_rvalid_i arrived with owner FIFO empty

## Operation
- FSM with states ARB and HOLD.
- ARB: if the FIFO is not full and at least one request is pending, select a winner and drive it onto mem_*. Instruction requests present mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- ARB to HOLD: mem_req_o=1 and mem_gnt_i=0. The selection is registered and the mem_* fields stay stable from that selection until grant; requesters must hold their request stable until they see gnt.
- HOLD to ARB: on mem_gnt_i=1.
- A grant (mem_req_o && mem_gnt_i) asserts the winner's gnt_o in the same cycle only, and pushes the owner ID (0 = instr, 1 = data) into the FIFO.
- Response routing: mem_rvalid_i pops the FIFO head and asserts the matching rvalid_o, with rdata_o = mem_rdata_i. The non-owner's rvalid_o stays 0, and its rdata_o is 0.
- Full: when the count equals MAX_OUTSTANDING, mem_req_o=0 in ARB, even if a pop occurs the same cycle. HOLD is unaffected, because it is only entered when a slot is free.
- Push and pop in the same cycle are legal; the count is unchanged.
- Empty pop: mem_rvalid_i with count 0 drops the response, asserts no rvalid_o, and pulses spurious_o. The count stays at 0 and does not wrap.
- FIFO pointers are log2(MAX_OUTSTANDING) bits wide and wrap modulo MAX_OUTSTANDING. The count is log2(MAX_OUTSTANDING)+1 bits wide.

## Timing
- Reset values:
  - all gnt_o, rvalid_o, rdata_o, mem_* outputs and spurious_o are 0
  - FSM is in ARB
  - FIFO is empty
  - last_winner = data
- Request-to-grant latency is 0 cycles when the memory grants combinationally and nothing is outstanding.
- Response latency adds 0 cycles; rvalid/rdata are combinational pass-through using the registered FIFO head.
- Reset asserted mid-transaction clears the FIFO and FSM immediately. Responses that arrive after reset release count as spurious.

## Configuration
- RISCY_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the requester that did not win last is chosen.
  - last_winner updates on every grant.
- RISCY_ARB_RR_EN undefined: fixed priority, data over instr. last_winner is unused.

## Test plan
- Single fetch: instr_req_i=1, addr 0x0000_0080, mem_gnt_i=1.
  - Required: instr_gnt_o=1 in the same cycle.
  - Next cycle, mem_rvalid_i=1 with rdata 0x0000_001B gives instr_rvalid_o=1 and instr_rdata_o=0x0000_001B.
- Simultaneous requests for 4 cycles, memory always grants, responses 1 cycle later.
  - RR: grant order is instr, data, instr, data.
  - Fixed priority: data on every cycle.
- Store hold: data_req_i=1, we=1, be=4'h3, addr 0x100, wdata 0xDEADBEEF, mem_gnt_i held low 3 cycles.
  - Required: mem_* stable for 3 cycles and data_gnt_o=0.
  - A competing instr_req_i raised in cycle 2 must not win.
  - Grant on cycle 4 gives data_gnt_o=1.
- Full stall with MAX_OUTSTANDING=2: two grants, then no responses.
  - Required: mem_req_o=0 while both are outstanding.
  - The first mem_rvalid_i is routed to the oldest owner, and the next request is granted the following cycle.
- Push and pop in the same cycle at count 1: count stays 1, and the response goes to the older owner.
- Spurious response and mid-flight reset:
  - mem_rvalid_i with an empty FIFO gives a one-cycle spurious_o pulse and no rvalid_o.
  - rst_ni low with 2 outstanding clears them, and all outputs read 0 during reset.
